// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller slice.
// Contents:
//   - controller state enum (IDLE, RD_MEM, REFILL, WR_MEM)
//   - cache geometry constants (address split, line count, block width)
//   - width of the memory-latency counter
package cache_pkg;

  // Cache geometry: 10-bit word address = tag | index | word offset.
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned TAG_W    = 3;
  localparam int unsigned INDEX_W  = 5;
  localparam int unsigned OFFSET_W = 2;
  localparam int unsigned LINES    = 32;
  localparam int unsigned BLOCK_W  = 128;

  // Latency counter width; memory latencies are limited to 1..15.
  localparam int unsigned LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_MEM = 2'd1,
    REFILL = 2'd2,
    WR_MEM = 2'd3
  } state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Load/decrement counter used to time data-memory accesses.
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset (count cleared to 0)
//   load     - load load_val (has priority over dec)
//   load_val - value to load
//   dec      - decrement by one; ignored when already zero
//   zero     - count is zero
module mem_wait_counter
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [LAT_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic                 zero
);

  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      // Saturate at zero so the count never wraps.
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cache_controller.sv
// Sequencing FSM for the direct-mapped write-through cache and its data memory.
// Accepts single-word load/store requests from the core, drives the cache and
// data-memory strobes, stalls the core on misses and write-through, and times
// fixed memory latencies with mem_wait_counter.
// Build option:
//   CACHE_WR_ALLOCATE_EN - when defined, a write miss first refills the line and
//                          then takes the write-hit path (write-allocate).
//                          Default (undefined) is write-no-allocate.
// Parameters:
//   MEM_RD_LAT - block-read latency in cycles (1..15)
//   MEM_WR_LAT - word-write latency in cycles (1..15)
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   cpu_rd_req      - core load request (held while stall)
//   cpu_wr_req      - core store request (held while stall)
//   hit_miss        - cache hit for the current address
//   rd_en_cm        - cache read strobe
//   wr_en_cm        - cache word-write strobe
//   mem_to_cache_en - cache block-refill strobe
//   mem_rd_en       - data-memory block read in progress
//   mem_wr_en       - data-memory word write in progress
//   stall           - core must hold request and address
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 4,
  parameter int unsigned MEM_WR_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_rd_req,
  input  logic cpu_wr_req,
  input  logic hit_miss,
  output logic rd_en_cm,
  output logic wr_en_cm,
  output logic mem_to_cache_en,
  output logic mem_rd_en,
  output logic mem_wr_en,
  output logic stall
);

  localparam logic [LAT_CNT_W-1:0] RdLoad = LAT_CNT_W'(MEM_RD_LAT - 1);
  localparam logic [LAT_CNT_W-1:0] WrLoad = LAT_CNT_W'(MEM_WR_LAT - 1);

  state_e state_q, state_d;

  logic                 cnt_load;
  logic [LAT_CNT_W-1:0] cnt_load_val;
  logic                 cnt_dec;
  logic                 cnt_zero;

  logic rd_en_c, wr_en_c, refill_c, mem_rd_c, mem_wr_c, stall_c;

  mem_wait_counter u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    rd_en_c      = 1'b0;
    wr_en_c      = 1'b0;
    refill_c     = 1'b0;
    mem_rd_c     = 1'b0;
    mem_wr_c     = 1'b0;
    stall_c      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Stores win over loads when both are requested.
        if (cpu_wr_req) begin
          stall_c = 1'b1;
          if (hit_miss) begin
            wr_en_c      = 1'b1;
            state_d      = WR_MEM;
            cnt_load     = 1'b1;
            cnt_load_val = WrLoad;
          end else begin
`ifdef CACHE_WR_ALLOCATE_EN
            // Refill first; the returning IDLE cycle then sees a write hit.
            state_d      = RD_MEM;
            cnt_load     = 1'b1;
            cnt_load_val = RdLoad;
`else
            state_d      = WR_MEM;
            cnt_load     = 1'b1;
            cnt_load_val = WrLoad;
`endif
          end
        end else if (cpu_rd_req) begin
          if (hit_miss) begin
            rd_en_c = 1'b1;
          end else begin
            stall_c      = 1'b1;
            state_d      = RD_MEM;
            cnt_load     = 1'b1;
            cnt_load_val = RdLoad;
          end
        end
      end

      RD_MEM: begin
        mem_rd_c = 1'b1;
        stall_c  = 1'b1;
        if (cnt_zero) begin
          state_d = REFILL;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      REFILL: begin
        refill_c = 1'b1;
        stall_c  = 1'b1;
        state_d  = IDLE;
      end

      WR_MEM: begin
        mem_wr_c = 1'b1;
        // The final write cycle releases the core.
        if (cnt_zero) begin
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_dec = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Gate with reset so no strobe is seen while rst_n is low, even though
  // IDLE decoding would otherwise react to held requests.
  assign rd_en_cm        = rst_n & rd_en_c;
  assign wr_en_cm        = rst_n & wr_en_c;
  assign mem_to_cache_en = rst_n & refill_c;
  assign mem_rd_en       = rst_n & mem_rd_c;
  assign mem_wr_en       = rst_n & mem_wr_c;
  assign stall           = rst_n & stall_c;

endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing FSM for the direct-mapped, 32-line, 128-bit-block instruction/data cache and its backing data memory. It accepts single-word read/write requests from the RISC-V core and drives the cache strobes (`rd_en_cm`, `wr_en_cm`, `mem_to_cache_en`) and the data-memory strobes. It stalls the core on misses and write-through, and counts fixed memory latency. Sits between the core's memory stage and the cache/data-memory pair; address and data buses bypass it.

## Interface
- `MEM_RD_LAT`, default 4: data-memory block-read latency in cycles, legal 1..15.
- `MEM_WR_LAT`, default 4: data-memory word-write latency in cycles, legal 1..15.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: reset; one clock, reset is asynchronous and active-low.
- `cpu_rd_req` in 1: core load request, held until a cycle with `stall`=0.
- `cpu_wr_req` in 1: core store request, held until a cycle with `stall`=0.
- `hit_miss` in 1: cache hit indication for the current address (combinational from cache).
- `rd_en_cm` out 1: cache read strobe.
- `wr_en_cm` out 1: cache word-write strobe.
- `mem_to_cache_en` out 1: cache block-refill strobe (also sets tag/valid).
- `mem_rd_en` out 1: data-memory block read in progress.
- `mem_wr_en` out 1: data-memory word write in progress.
- `stall` out 1: core must hold request and address this cycle.

## Operation
- States: IDLE, RD_MEM, REFILL, WR_MEM. Outputs are decoded combinationally from state, requests and `hit_miss`. The cache strobes are mutually exclusive in every cycle.
- **IDLE, no request:** all outputs 0.
- **IDLE, read, hit:** `rd_en_cm`=1, `stall`=0; stay in IDLE.
- **IDLE, read, miss:** `stall`=1. Go to RD_MEM and load the counter with `MEM_RD_LAT`-1.
- **IDLE, write, hit:** `wr_en_cm`=1, `stall`=1. Go to WR_MEM and load the counter with `MEM_WR_LAT`-1.
- **IDLE, write, miss:** without allocate, `stall`=1 and go to WR_MEM (no cache update). With allocate, see Configuration.
- **Both requests high:** write takes priority; the read is ignored.
- **RD_MEM:** `mem_rd_en`=1, `stall`=1. Decrement the counter; at 0 go to REFILL.
- **REFILL:** `mem_to_cache_en`=1, `stall`=1; go to IDLE. The next IDLE cycle sees a hit and completes the access.
- **WR_MEM:** `mem_wr_en`=1. `stall`=1 while counter≠0. At counter 0, `stall`=0 (store completes) and go to IDLE.
- The write-through policy guarantees memory always holds current data; no dirty state exists.
- Requests arriving while not in IDLE are not sampled.

## Timing
- **Reset:** state=IDLE, counter=0. All outputs 0 while `rst_n`=0. Reset asserted mid-operation aborts immediately; no strobe is left high.
- **Read hit:** 0 added cycles; data valid in the request cycle.
- **Read miss:** `stall` high for `MEM_RD_LAT`+2 cycles; data in cycle `MEM_RD_LAT`+3.
- **Write (hit or no-allocate miss):** `stall` high for `MEM_WR_LAT` cycles, then low in the final WR_MEM cycle. `mem_wr_en` is high for exactly `MEM_WR_LAT` cycles.
- **Counter:** 4 bits, unsigned, decrement only, never wraps; the state leaves before 0-1.

## Configuration
- `CACHE_WR_ALLOCATE_EN` defined: a write miss goes IDLE→RD_MEM→REFILL→IDLE. The controller then takes the write-hit path, so the cache is updated and memory is written through. Total stall is `MEM_RD_LAT`+`MEM_WR_LAT`+2 cycles.
- Undefined (default): write-no-allocate. A write miss updates memory only; the cache is untouched.

## Structure
- `cache_pkg` holds:
  - the state enum (`IDLE`, `RD_MEM`, `REFILL`, `WR_MEM`);
  - geometry constants `ADDR_W`=10, `TAG_W`=3, `INDEX_W`=5, `OFFSET_W`=2, `LINES`=32, `BLOCK_W`=128;
  - `LAT_CNT_W`=4.
- One sub-module, `mem_wait_counter`: load/decrement counter with a `zero` flag, shared by the RD_MEM and WR_MEM paths.

## Test plan
- **Reset:** `rst_n` low for 3 cycles with requests high → all outputs 0; after release, idle outputs 0.
- **Read hit:** `cpu_rd_req`=1, `hit_miss`=1 → `rd_en_cm`=1, `stall`=0 in the same cycle.
- **Read miss:** `MEM_RD_LAT`=4, read with `hit_miss`=0 → `mem_rd_en` high 4 cycles, `mem_to_cache_en` 1 cycle, `stall` high 6 cycles, `rd_en_cm` in cycle 7.
- **Write:**
  - `MEM_WR_LAT`=3, write hit → `wr_en_cm` 1 cycle, `mem_wr_en` 3 cycles, `stall` high 3 cycles.
  - Write miss without macro → `wr_en_cm` never high.
- **Allocate:** with `CACHE_WR_ALLOCATE_EN`, `MEM_RD_LAT`=4, `MEM_WR_LAT`=3, write miss → refill sequence, then `wr_en_cm`; `stall` high 9 cycles total.
- **Edge cases:**
  - Both requests high with hit → write path taken.
  - `rst_n` dropped in RD_MEM cycle 2 → `mem_rd_en` low immediately; after release, IDLE.
